// File: rtl/star_pkg.sv
// Shared constants for the grill/star motor-command interface.
// Used by the plant model and by the star hiding controller.
//   - Position sensor codes (2 bits per axis)
//   - Bit positions inside the 4-bit motor command word
//   - Per-axis status enum
package star_pkg;

    localparam logic [1:0] POS_LOW  = 2'b00;
    localparam logic [1:0] POS_HIGH = 2'b01;
    localparam logic [1:0] POS_MID  = 2'b10;

    localparam int CMD_OPEN  = 3;
    localparam int CMD_CLOSE = 2;
    localparam int CMD_HIDE  = 1;
    localparam int CMD_RAISE = 0;

    typedef enum logic [2:0] {
        AT_LOW,
        MOVING_UP,
        MOVING_DOWN,
        STOPPED_MID,
        AT_HIGH
    } axis_status_e;

endpackage

// File: rtl/plant_axis.sv
// One actuator axis: a saturating travel counter with position decode.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (count reloads INIT)
//   inc, dec       : requested direction; both set means no motion
//   enable         : interlock permit from the top level
//   count          : registered travel count, 0..TRAVEL
//   pos            : POS_LOW at 0, POS_HIGH at TRAVEL, POS_MID between
//   moved          : registered, 1 iff count changed on the last edge
//   status         : axis status FSM state
module plant_axis
    import star_pkg::*;
#(
    parameter int TRAVEL = 16,
    parameter int INIT   = 0,
    localparam int CW    = $clog2(TRAVEL + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic [1:0]    pos,
    output logic          moved,
    output axis_status_e  status
);

    localparam logic [CW-1:0] MAX      = CW'(TRAVEL);
    localparam logic [CW-1:0] INIT_CNT = CW'(INIT);
    localparam axis_status_e  RST_STATUS = (INIT == 0)      ? AT_LOW  :
                                           (INIT == TRAVEL) ? AT_HIGH : STOPPED_MID;

    logic          step_up;
    logic          step_dn;
    logic [CW-1:0] count_nxt;
    axis_status_e  status_nxt;

    // Steps are gated at the ends so the count saturates instead of wrapping.
    assign step_up = enable & inc & ~dec & (count != MAX);
    assign step_dn = enable & dec & ~inc & (count != '0);

    always_comb begin
        count_nxt = count;
        if (step_up)      count_nxt = count + 1'b1;
        else if (step_dn) count_nxt = count - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= INIT_CNT;
            moved <= 1'b0;
        end else begin
            count <= count_nxt;
            moved <= step_up | step_dn;
        end
    end

    always_comb begin
        pos = POS_MID;
        if (count == '0)       pos = POS_LOW;
        else if (count == MAX) pos = POS_HIGH;
    end

    // Status tracks the count after the edge and the direction just applied;
    // no motion between the ends means the axis was stopped mid-travel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) status <= RST_STATUS;
        else          status <= status_nxt;
    end

    always_comb begin
        status_nxt = status;
        if (step_up)
            status_nxt = (count_nxt == MAX) ? AT_HIGH : MOVING_UP;
        else if (step_dn)
            status_nxt = (count_nxt == '0) ? AT_LOW : MOVING_DOWN;
        else if (count == '0)
            status_nxt = AT_LOW;
        else if (count == MAX)
            status_nxt = AT_HIGH;
        else
            status_nxt = STOPPED_MID;
    end

endmodule

// File: rtl/grill_star_plant.sv
// Grill and star mechanism plant: device side of the motor-command interface.
// Holds the interlocks between the two axes and the sticky fault flag.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_cmd          : [3] open grill, [2] close grill, [1] hide star, [0] raise star
//   i_fault_clr    : synchronous clear of o_fault (a new fault on the same edge wins)
//   o_grill_pos    : 00 closed, 01 open, 10 intermediate
//   o_star_pos     : 00 up, 01 hidden, 10 intermediate
//   o_busy         : 1 iff either axis count changed on the last edge
//   o_fault        : sticky illegal-command flag
module grill_star_plant
    import star_pkg::*;
#(
    parameter int GRILL_TRAVEL = 16,
    parameter int STAR_TRAVEL  = 8,
    parameter int INIT_GRILL   = 0,
    parameter int INIT_STAR    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cmd,
    input  logic       i_fault_clr,
    output logic [1:0] o_grill_pos,
    output logic [1:0] o_star_pos,
    output logic       o_busy,
    output logic       o_fault
);

    localparam int GW = $clog2(GRILL_TRAVEL + 1);
    localparam int SW = $clog2(STAR_TRAVEL + 1);

    logic [GW-1:0] grill_cnt;
    logic [SW-1:0] star_cnt;
    logic          grill_moved;
    logic          star_moved;
    axis_status_e  grill_status;
    axis_status_e  star_status;

    logic star_at_end;
    logic grill_open;
    logic grill_req;
    logic star_req;
    logic fault_set;

    // Interlocks look at pre-edge counts only, so one edge can never start
    // both axes out of an illegal configuration.
    assign star_at_end = (star_cnt == '0) || (star_cnt == SW'(STAR_TRAVEL));
    assign grill_open  = (grill_cnt == GW'(GRILL_TRAVEL));

    assign grill_req = i_cmd[CMD_OPEN] | i_cmd[CMD_CLOSE];
    assign star_req  = i_cmd[CMD_HIDE] | i_cmd[CMD_RAISE];

    assign fault_set = (i_cmd[CMD_OPEN] & i_cmd[CMD_CLOSE])
                     | (i_cmd[CMD_HIDE] & i_cmd[CMD_RAISE])
                     | (star_req  & ~grill_open)
                     | (grill_req & ~star_at_end);

    plant_axis #(.TRAVEL(GRILL_TRAVEL), .INIT(INIT_GRILL)) u_grill (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .inc     (i_cmd[CMD_OPEN]),
        .dec     (i_cmd[CMD_CLOSE]),
        .enable  (star_at_end),
        .count   (grill_cnt),
        .pos     (o_grill_pos),
        .moved   (grill_moved),
        .status  (grill_status)
    );

    plant_axis #(.TRAVEL(STAR_TRAVEL), .INIT(INIT_STAR)) u_star (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .inc     (i_cmd[CMD_HIDE]),
        .dec     (i_cmd[CMD_RAISE]),
        .enable  (grill_open),
        .count   (star_cnt),
        .pos     (o_star_pos),
        .moved   (star_moved),
        .status  (star_status)
    );

    assign o_busy = grill_moved | star_moved;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         o_fault <= 1'b0;
        else if (fault_set)   o_fault <= 1'b1;
        else if (i_fault_clr) o_fault <= 1'b0;
    end

endmodule

// File: tb/tb_grill_star_plant.sv
module tb_grill_star_plant;
    import star_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [3:0] i_cmd = 4'b0000;
    logic       i_fault_clr = 1'b0;
    logic [1:0] o_grill_pos, o_star_pos, hi_grill_pos, hi_star_pos;
    logic       o_busy, o_fault, hi_busy, hi_fault;

    int checks = 0;
    int passes = 0;

    always #5 i_clk = ~i_clk;

    grill_star_plant dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd       (i_cmd),
        .i_fault_clr (i_fault_clr),
        .o_grill_pos (o_grill_pos),
        .o_star_pos  (o_star_pos),
        .o_busy      (o_busy),
        .o_fault     (o_fault)
    );

    grill_star_plant #(.INIT_GRILL(16), .INIT_STAR(8)) dut_hi (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd       (i_cmd),
        .i_fault_clr (i_fault_clr),
        .o_grill_pos (hi_grill_pos),
        .o_star_pos  (hi_star_pos),
        .o_busy      (hi_busy),
        .o_fault     (hi_fault)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_fault();
        i_cmd = 4'b0000;
        i_fault_clr = 1'b1;
        tick(1);
        i_fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_cmd = 4'b0000;
        tick(5);
        checks++; if (o_grill_pos !== 2'b00) $display("FAIL reset_grill got=%b exp=00", o_grill_pos); else passes++;
        checks++; if (o_star_pos !== 2'b00) $display("FAIL reset_star got=%b exp=00", o_star_pos); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else passes++;
        checks++; if (o_fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", o_fault); else passes++;
        checks++; if (hi_grill_pos !== 2'b01 || hi_star_pos !== 2'b01)
            $display("FAIL reset_init_hi got=%b/%b exp=01/01", hi_grill_pos, hi_star_pos); else passes++;
        #3 i_rst_n = 1'b1;
        tick(1);
        checks++; if (o_grill_pos !== 2'b00 || o_busy !== 1'b0)
            $display("FAIL idle_hold got=%b/%b exp=00/0", o_grill_pos, o_busy); else passes++;
    endtask

    task automatic test_open();
        i_cmd = 4'b1000;
        tick(1);
        checks++; if (o_grill_pos !== 2'b10 || o_busy !== 1'b1)
            $display("FAIL open_edge1 got=%b/%b exp=10/1", o_grill_pos, o_busy); else passes++;
        tick(14);
        checks++; if (o_grill_pos !== 2'b10) $display("FAIL open_edge15 got=%b exp=10", o_grill_pos); else passes++;
        tick(1);
        checks++; if (o_grill_pos !== 2'b01 || o_busy !== 1'b1)
            $display("FAIL open_edge16 got=%b/%b exp=01/1", o_grill_pos, o_busy); else passes++;
        tick(1);
        checks++; if (o_grill_pos !== 2'b01 || o_busy !== 1'b0 || o_fault !== 1'b0)
            $display("FAIL open_saturate got=%b/%b/%b exp=01/0/0", o_grill_pos, o_busy, o_fault); else passes++;
    endtask

    task automatic test_star();
        i_cmd = 4'b0010;
        tick(1);
        checks++; if (o_star_pos !== 2'b10 || o_busy !== 1'b1)
            $display("FAIL hide_edge1 got=%b/%b exp=10/1", o_star_pos, o_busy); else passes++;
        tick(3);
        // grill command with star intermediate: fault, grill stays open
        i_cmd = 4'b0100;
        tick(1);
        checks++; if (o_grill_pos !== 2'b01 || o_star_pos !== 2'b10 || o_fault !== 1'b1)
            $display("FAIL grill_star_mid got=%b/%b/%b exp=01/10/1", o_grill_pos, o_star_pos, o_fault); else passes++;
        clear_fault();
        checks++; if (o_fault !== 1'b0) $display("FAIL fault_clr1 got=%b exp=0", o_fault); else passes++;
        i_cmd = 4'b0010;
        tick(3);
        checks++; if (o_star_pos !== 2'b10) $display("FAIL hide_edge7 got=%b exp=10", o_star_pos); else passes++;
        tick(1);
        checks++; if (o_star_pos !== 2'b01 || o_fault !== 1'b0)
            $display("FAIL hide_edge8 got=%b/%b exp=01/0", o_star_pos, o_fault); else passes++;
        i_cmd = 4'b0100;
        tick(15);
        checks++; if (o_grill_pos !== 2'b10) $display("FAIL close_edge15 got=%b exp=10", o_grill_pos); else passes++;
        tick(1);
        checks++; if (o_grill_pos !== 2'b00 || o_star_pos !== 2'b01 || o_fault !== 1'b0)
            $display("FAIL close_done got=%b/%b/%b exp=00/01/0", o_grill_pos, o_star_pos, o_fault); else passes++;
    endtask

    task automatic test_interlock();
        i_cmd = 4'b0010;
        tick(1);
        checks++; if (o_star_pos !== 2'b01 || o_busy !== 1'b0 || o_fault !== 1'b1)
            $display("FAIL star_lock got=%b/%b/%b exp=01/0/1", o_star_pos, o_busy, o_fault); else passes++;
        clear_fault();
        checks++; if (o_fault !== 1'b0) $display("FAIL fault_clr2 got=%b exp=0", o_fault); else passes++;
        // clear and a new fault on the same edge: set wins
        i_cmd = 4'b0001;
        i_fault_clr = 1'b1;
        tick(1);
        i_fault_clr = 1'b0;
        checks++; if (o_fault !== 1'b1 || o_star_pos !== 2'b01)
            $display("FAIL set_wins got=%b/%b exp=1/01", o_fault, o_star_pos); else passes++;
        clear_fault();
    endtask

    task automatic test_conflict();
        i_cmd = 4'b1100;
        tick(1);
        checks++; if (o_grill_pos !== 2'b00 || o_busy !== 1'b0 || o_fault !== 1'b1)
            $display("FAIL conflict got=%b/%b/%b exp=00/0/1", o_grill_pos, o_busy, o_fault); else passes++;
        clear_fault();
        i_cmd = 4'b1000;
        tick(5);
        i_cmd = 4'b0000;
        tick(1);
        checks++; if (o_grill_pos !== 2'b10 || o_busy !== 1'b0 || o_fault !== 1'b0)
            $display("FAIL stop_mid got=%b/%b/%b exp=10/0/0", o_grill_pos, o_busy, o_fault); else passes++;
        checks++; if (dut.u_grill.status !== STOPPED_MID)
            $display("FAIL stop_status got=%0d exp=%0d", dut.u_grill.status, STOPPED_MID); else passes++;
        i_cmd = 4'b1000;
        tick(10);
        checks++; if (o_grill_pos !== 2'b10) $display("FAIL resume_10 got=%b exp=10", o_grill_pos); else passes++;
        tick(1);
        checks++; if (o_grill_pos !== 2'b01) $display("FAIL resume_11 got=%b exp=01", o_grill_pos); else passes++;
    endtask

    task automatic test_async_reset();
        i_cmd = 4'b0000;
        i_rst_n = 1'b0;
        tick(1);
        #3 i_rst_n = 1'b1;
        tick(1);
        i_cmd = 4'b0001;
        tick(1);
        i_cmd = 4'b1000;
        tick(7);
        checks++; if (o_grill_pos !== 2'b10 || o_fault !== 1'b1)
            $display("FAIL pre_reset got=%b/%b exp=10/1", o_grill_pos, o_fault); else passes++;
        #3 i_rst_n = 1'b0;
        #1;
        checks++; if (o_grill_pos !== 2'b00 || o_star_pos !== 2'b00 || o_fault !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL async_reset got=%b/%b/%b/%b exp=00/00/0/0", o_grill_pos, o_star_pos, o_fault, o_busy); else passes++;
        checks++; if (hi_grill_pos !== 2'b01 || hi_star_pos !== 2'b01)
            $display("FAIL async_reset_hi got=%b/%b exp=01/01", hi_grill_pos, hi_star_pos); else passes++;
        i_cmd = 4'b0000;
        tick(2);
        #3 i_rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_open();
        test_star();
        test_interlock();
        test_conflict();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
